// File: rtl/risc_pkg.sv
// Shared definitions for the small RISC core: opcode and controller phase
// encodings, plus the ALU-operation classifier used by the controller.
package risc_pkg;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   // Opcodes that read an operand from memory and write the accumulator.
   function automatic logic is_aluop(input opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the RISC core. One phase per clock,
// with a sticky halt in OP_ADDR that only a resume pulse releases.
module cpu_controller
   import risc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       resume,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic       halt,
   output logic [2:0] phase
);

   phase_t     r_phase;
   logic       r_halt;
   opcode_t    w_op;
   logic       w_aluop;
   logic [2:0] w_phase_inc;

   assign w_op        = opcode_t'(opcode);
   assign w_aluop     = is_aluop(w_op);
   assign w_phase_inc = r_phase + 3'd1;
   assign phase       = r_phase;

   // The halt flag is set on the first OP_ADDR clock of a HLT, so the PC
   // strobe in OP_ADDR fires only once; resume is ignored unless the flag is set.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase <= INST_ADDR;
         r_halt  <= 1'b0;
      end else if (r_halt) begin
         if (resume) begin
            r_phase <= OP_FETCH;
            r_halt  <= 1'b0;
         end
      end else if (r_phase == OP_ADDR && w_op == HLT) begin
         r_halt <= 1'b1;
      end else begin
         r_phase <= phase_t'(w_phase_inc);
      end
   end

   // NOTE: every output gets a default before the case, otherwise phases that
   // leave a strobe unassigned would infer a latch.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = r_halt;
      case (r_phase)
         INST_ADDR: begin
            sel = 1'b1;
         end
         INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         OP_ADDR: begin
            inc_pc = ~r_halt;
            halt   = r_halt | (w_op == HLT);
         end
         OP_FETCH: begin
            rd = w_aluop;
         end
         ALU_OP: begin
            rd     = w_aluop;
            inc_pc = (w_op == SKZ) && zero;
            ld_pc  = (w_op == JMP);
            data_e = (w_op == STO);
         end
         STORE: begin
            rd     = w_aluop;
            ld_ac  = w_aluop;
            inc_pc = (w_op == JMP);
            ld_pc  = (w_op == JMP);
            wr     = (w_op == STO);
            data_e = (w_op == STO);
         end
         default: begin
            sel = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: the stimulus pushes hand-written
// expected phase/strobe vectors, a monitor pops and compares them.
module tb_cpu_controller;
   import risc_pkg::*;

   logic       clk;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       resume;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;

   // Strobe vector layout: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
   localparam logic [8:0] S_NONE  = 9'b000000000;
   localparam logic [8:0] S_SEL   = 9'b100000000;
   localparam logic [8:0] S_FETCH = 9'b110000000;
   localparam logic [8:0] S_LOAD  = 9'b111000000;
   localparam logic [8:0] S_INC   = 9'b000100000;
   localparam logic [8:0] S_RD    = 9'b010000000;
   localparam logic [8:0] S_RDAC  = 9'b010001000;
   localparam logic [8:0] S_DE    = 9'b000000010;
   localparam logic [8:0] S_WRDE  = 9'b000000110;
   localparam logic [8:0] S_LDPC  = 9'b000010000;
   localparam logic [8:0] S_JMP7  = 9'b000110000;
   localparam logic [8:0] S_HLT1  = 9'b000100001;
   localparam logic [8:0] S_HALT  = 9'b000000001;

   typedef struct packed {
      logic [2:0] ph;
      logic [8:0] strobes;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   event sample_now;

   cpu_controller dut (
      .clk    (clk),
      .rst    (rst),
      .opcode (opcode),
      .zero   (zero),
      .resume (resume),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .data_e (data_e),
      .halt   (halt),
      .phase  (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                  name, act[11:9], act[8:0], req[11:9], req[8:0]);
      end
   endtask

   // Monitor: compares the DUT against the oldest outstanding expectation.
   initial begin
      exp_t       e;
      logic [8:0] act_s;
      forever begin
         @(negedge clk or sample_now);
         if (exp_q.size() != 0) begin
            e     = exp_q.pop_front();
            act_s = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
            check($sformatf("vec%0d", n_tests), {phase, act_s}, e);
            check("no_wr_with_rd", {3'd0, 8'd0, wr & rd}, 12'd0);
         end
      end
   end

   // One clock: drive inputs just after the edge and queue this cycle's expectation.
   task automatic cycle(input opcode_t op, input logic z, input logic res,
                        input logic [2:0] ph, input logic [8:0] s);
      exp_t e;
      @(posedge clk);
      #1;
      opcode = op;
      zero   = z;
      resume = res;
      rst    = 1'b0;
      e.ph = ph;
      e.strobes = s;
      exp_q.push_back(e);
   endtask

   task automatic fetch(input opcode_t op, input logic z);
      cycle(op, z, 1'b0, 3'd0, S_SEL);
      cycle(op, z, 1'b0, 3'd1, S_FETCH);
      cycle(op, z, 1'b0, 3'd2, S_LOAD);
      cycle(op, z, 1'b0, 3'd3, S_LOAD);
   endtask

   initial begin
      exp_t e;
      int   guard;
      rst    = 1'b1;
      opcode = ADD;
      zero   = 1'b0;
      resume = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e.ph = 3'd0;
      e.strobes = S_SEL;
      exp_q.push_back(e);

      // ADD from reset; rst released in the first phase-0 cycle
      fetch(ADD, 1'b0);
      cycle(ADD, 1'b0, 1'b0, 3'd4, S_INC);
      cycle(ADD, 1'b0, 1'b0, 3'd5, S_RD);
      cycle(ADD, 1'b0, 1'b0, 3'd6, S_RD);
      cycle(ADD, 1'b0, 1'b0, 3'd7, S_RDAC);

      // SKZ with zero set, then clear
      fetch(SKZ, 1'b1);
      cycle(SKZ, 1'b1, 1'b0, 3'd4, S_INC);
      cycle(SKZ, 1'b1, 1'b0, 3'd5, S_NONE);
      cycle(SKZ, 1'b1, 1'b0, 3'd6, S_INC);
      cycle(SKZ, 1'b1, 1'b0, 3'd7, S_NONE);
      fetch(SKZ, 1'b0);
      cycle(SKZ, 1'b0, 1'b0, 3'd4, S_INC);
      cycle(SKZ, 1'b0, 1'b0, 3'd5, S_NONE);
      cycle(SKZ, 1'b0, 1'b0, 3'd6, S_NONE);
      cycle(SKZ, 1'b0, 1'b0, 3'd7, S_NONE);

      // STO and JMP
      fetch(STO, 1'b0);
      cycle(STO, 1'b0, 1'b0, 3'd4, S_INC);
      cycle(STO, 1'b0, 1'b0, 3'd5, S_NONE);
      cycle(STO, 1'b0, 1'b0, 3'd6, S_DE);
      cycle(STO, 1'b0, 1'b0, 3'd7, S_WRDE);
      fetch(JMP, 1'b1);
      cycle(JMP, 1'b1, 1'b0, 3'd4, S_INC);
      cycle(JMP, 1'b1, 1'b0, 3'd5, S_NONE);
      cycle(JMP, 1'b1, 1'b0, 3'd6, S_LDPC);
      cycle(JMP, 1'b1, 1'b0, 3'd7, S_JMP7);

      // HLT: PC strobe once, held for 10 more clocks, then resume
      fetch(HLT, 1'b0);
      cycle(HLT, 1'b0, 1'b0, 3'd4, S_HLT1);
      for (int i = 0; i < 10; i++) cycle(HLT, 1'b0, 1'b0, 3'd4, S_HALT);
      cycle(HLT, 1'b0, 1'b1, 3'd4, S_HALT);
      cycle(HLT, 1'b0, 1'b0, 3'd5, S_NONE);
      cycle(HLT, 1'b0, 1'b0, 3'd6, S_NONE);
      cycle(HLT, 1'b0, 1'b0, 3'd7, S_NONE);

      // Resume while running has no effect
      cycle(ADD, 1'b0, 1'b0, 3'd0, S_SEL);
      cycle(ADD, 1'b0, 1'b0, 3'd1, S_FETCH);
      cycle(ADD, 1'b0, 1'b1, 3'd2, S_LOAD);
      cycle(ADD, 1'b0, 1'b0, 3'd3, S_LOAD);
      cycle(ADD, 1'b0, 1'b0, 3'd4, S_INC);
      cycle(ADD, 1'b0, 1'b0, 3'd5, S_RD);
      cycle(ADD, 1'b0, 1'b0, 3'd6, S_RD);
      cycle(ADD, 1'b0, 1'b0, 3'd7, S_RDAC);

      // Asynchronous reset in the middle of STO phase 5
      fetch(STO, 1'b0);
      cycle(STO, 1'b0, 1'b0, 3'd4, S_INC);
      cycle(STO, 1'b0, 1'b0, 3'd5, S_NONE);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      e.ph = 3'd0;
      e.strobes = S_SEL;
      exp_q.push_back(e);
      -> sample_now;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      cycle(STO, 1'b0, 1'b0, 3'd0, S_SEL);
      cycle(STO, 1'b0, 1'b0, 3'd1, S_FETCH);

      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      check("scoreboard_drained", {11'd0, exp_q.size() != 0}, 12'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter: none; all widths fixed (3-bit opcode, 3-bit phase).
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  input  3  instruction opcode from instruction register (HLT=0,SKZ=1,ADD=2,AND=3,XOR=4,LDA=5,STO=6,JMP=7).
REQ-005 SHALL have port zero  input  1  accumulator-is-zero flag from ALU.
REQ-006 SHALL have port resume  input  1  one-cycle pulse releasing halt.
REQ-007 SHALL have outputs sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e  output  1 each  datapath control strobes.
REQ-008 SHALL have port halt  output  1  processor halted indication.
REQ-009 SHALL have port phase  output  3  current phase, for debug/bench.

Function
REQ-010 SHALL sequence eight phases in order: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), wrapping 7->0.
REQ-011 SHALL advance exactly one phase per clock except while halted.
REQ-012 SHALL decode all control outputs combinationally from phase register and opcode/zero (no extra latency).
REQ-013 SHALL define ALUOP = opcode in {ADD, AND, XOR, LDA}.
REQ-014 SHALL drive in INST_ADDR: sel=1; all others 0.
REQ-015 SHALL drive in INST_FETCH: sel=1, rd=1.
REQ-016 SHALL drive in INST_LOAD and IDLE: sel=1, rd=1, ld_ir=1.
REQ-017 SHALL drive in OP_ADDR: inc_pc=1; halt=1 when opcode==HLT.
REQ-018 SHALL drive in OP_FETCH: rd=ALUOP.
REQ-019 SHALL drive in ALU_OP: rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP), data_e=(opcode==STO).
REQ-020 SHALL drive in STORE: rd=ALUOP, ld_ac=ALUOP, inc_pc=ld_pc=(opcode==JMP), wr=data_e=(opcode==STO).
REQ-021 SHALL, when phase==OP_ADDR and opcode==HLT, hold phase at OP_ADDR on following clocks with halt=1 and inc_pc=0 after the first cycle (PC incremented exactly once).
REQ-022 SHALL exit halt on the clock where resume=1, advancing to OP_FETCH; resume outside halt SHALL be ignored.
REQ-023 SHALL never assert wr and rd in the same cycle, nor ld_pc without JMP/SKZ context as specified.

Reset
REQ-024 SHALL, on rst=1, immediately set phase=INST_ADDR and internal halt flag=0, regardless of clock.
REQ-025 SHALL therefore present during reset: sel=1, all other strobes 0, halt=0, phase=0.
REQ-026 SHALL resume counting from INST_ADDR on the first rising edge after rst deasserts; reset mid-instruction SHALL abort it with no wr pulse.

Structure
REQ-027 SHALL import opcode enum and phase enum from shared package risc_pkg (opcode enum also used by the ALU).
REQ-028 SHALL be a single module: one always_ff for phase/halt flag, one always_comb for decode; no sub-module.

Verification
REQ-029 SHALL check reset: assert rst mid-phase 5 with opcode=STO -> phase=0 asynchronously, sel=1, wr=0, halt=0.
REQ-030 SHALL check ADD sequence: opcode=ADD from reset -> phases 0..7; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; inc_pc=1 only in phase 4.
REQ-031 SHALL check SKZ: opcode=SKZ, zero=1 -> inc_pc=1 in phases 4 and 6; zero=0 -> inc_pc=1 only in phase 4.
REQ-032 SHALL check STO/JMP: opcode=STO -> data_e=1 phases 6,7, wr=1 phase 7 only; opcode=JMP -> ld_pc=1 phases 6,7, inc_pc=1 phases 4,7.
REQ-033 SHALL check halt: opcode=HLT -> phase sticks at 4 for 10 clocks, halt=1, inc_pc pulses once; resume pulse -> phase 5 next clock, halt=0.
REQ-034 SHALL check resume while running (phase 2) -> no effect, sequence continues to phase 3.
